// File: rtl/mult_pkg.sv
// Shared FSM state and Booth recoding definitions for the sequential multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    // Recodes the {Q[0], Q_1} pair into the operation applied to the accumulator.
    function automatic logic [1:0] booth_op(input logic [1:0] pair);
        case (pair)
            2'b01:   booth_op = OP_ADD;
            2'b10:   booth_op = OP_SUB;
            default: booth_op = OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M into A, then arithmetic shift of {A,Q,Q_1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW:0]   a,
    input  logic [DW-1:0] q,
    input  logic          q_1,
    input  logic [DW:0]   m,
    output logic [DW:0]   a_next,
    output logic [DW-1:0] q_next,
    output logic          q_1_next
);

    logic [DW:0] sum;

    // A carries one guard bit so A-M cannot overflow for the most-negative operand.
    always_comb begin
        sum = a;
        case (booth_op({q[0], q_1}))
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
        a_next   = {sum[DW], sum[DW:1]};
        q_next   = {sum[0], q[DW-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_mult_unit.sv
// Sequential radix-2 Booth multiplier; done pulses L+1 cycles after start (L = WIDTH, or WIDTH+1
// with MULT_UNSIGNED_EN adding the is_unsigned port); start is ignored while busy.
module booth_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mc,
    input  logic [WIDTH-1:0] mp,
`ifdef MULT_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULT_UNSIGNED_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif
    localparam int CW = $clog2(DW + 1);
    localparam int PW = 2 * WIDTH;

    state_t        state;
    logic [DW:0]   a_reg;
    logic [DW-1:0] q_reg;
    logic          q_1_reg;
    logic [DW:0]   m_reg;
    logic [CW-1:0] count;

    logic [DW:0]   a_next;
    logic [DW-1:0] q_next;
    logic          q_1_next;
    logic [DW-1:0] mc_ext;
    logic [DW-1:0] mp_ext;
    logic [PW-1:0] product;

`ifdef MULT_UNSIGNED_EN
    assign mc_ext = {(is_unsigned ? 1'b0 : mc[WIDTH-1]), mc};
    assign mp_ext = {(is_unsigned ? 1'b0 : mp[WIDTH-1]), mp};
`else
    assign mc_ext = mc;
    assign mp_ext = mp;
`endif

    // The exact product always fits in the low 2*WIDTH bits of {A,Q}.
    assign product = PW'({a_reg, q_reg});

    booth_step #(.DW(DW)) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .q_1      (q_1_reg),
        .m        (m_reg),
        .a_next   (a_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            q_1_reg <= 1'b0;
            m_reg   <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg   <= {mc_ext[DW-1], mc_ext};
                        q_reg   <= mp_ext;
                        a_reg   <= '0;
                        q_1_reg <= 1'b0;
                        count   <= CW'(DW);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_reg   <= a_next;
                    q_reg   <= q_next;
                    q_1_reg <= q_1_next;
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    hi    <= product[PW-1:WIDTH];
                    lo    <= product[WIDTH-1:0];
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed bench for booth_mult_unit at WIDTH=32 (MULT_UNSIGNED_EN selects the unsigned-mode vectors).
module tb_booth_mult_unit;

    localparam int W = 32;
`ifdef MULT_UNSIGNED_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] mc;
    logic [W-1:0] mp;
`ifdef MULT_UNSIGNED_EN
    logic         is_uns;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    booth_mult_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mc          (mc),
        .mp          (mp),
`ifdef MULT_UNSIGNED_EN
        .is_unsigned (is_uns),
`endif
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_seen"}, 64'(done), 64'd1);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        mc = a; mp = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n;
        @(posedge clk); #1;
        issue(a, b);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_hi"}, 64'(hi), 64'(last_hi));
        check({tag, "_hold_lo"}, 64'(lo), 64'(last_lo));
        wait_done(tag, n);
        check({tag, "_latency"}, 64'(n + 3), 64'(L + 1));
        check({tag, "_hi"}, 64'(hi), 64'(ehi));
        check({tag, "_lo"}, 64'(lo), 64'(elo));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        last_hi = ehi;
        last_lo = elo;
    endtask

    initial begin
        int n;
        int d0;
        int t1;
        int t2;

        // Reset held with start asserted: start must be ignored.
        reset = 1'b1; start = 1'b1; mc = 32'd5; mp = 32'd5;
`ifdef MULT_UNSIGNED_EN
        is_uns = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        check("rst_start_ignored", 64'(busy), 64'd0);

        run_mult("7xm3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_mult("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_mult("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);

        // Abort by reset at RUN cycle 10.
        @(posedge clk); #1;
        d0 = done_cnt;
        issue(32'd11, 32'd13);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        repeat (L + 5) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        last_hi = '0; last_lo = '0;

        // Start re-asserted mid-run must not disturb 5*6.
        @(posedge clk); #1;
        d0 = done_cnt;
        issue(32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        mc = 32'd9; mp = 32'd9; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0; mc = '0; mp = '0;
        wait_done("busy_start", n);
        check("busy_start_hi", 64'(hi), 64'd0);
        check("busy_start_lo", 64'(lo), 64'd30);
        repeat (L + 5) @(posedge clk);
        #1;
        check("busy_start_pulses", 64'(done_cnt), 64'(d0 + 1));

        // Back-to-back: second start in the IDLE cycle carrying done.
        @(posedge clk); #1;
        issue(32'd3, 32'd4);
        wait_done("b2b_first", n);
        t1 = cyc;
        check("b2b_first_hi", 64'(hi), 64'd0);
        check("b2b_first_lo", 64'(lo), 64'd12);
        issue(32'hFFFF_FFFE, 32'hFFFF_FFFE);
        check("b2b_accept", 64'(busy), 64'd1);
        wait_done("b2b_second", n);
        t2 = cyc;
        check("b2b_spacing", 64'(t2 - t1), 64'(L + 2));
        check("b2b_second_hi", 64'(hi), 64'd0);
        check("b2b_second_lo", 64'(lo), 64'd4);
        last_hi = 32'd0; last_lo = 32'd4;

`ifdef MULT_UNSIGNED_EN
        is_uns = 1'b1;
        run_mult("uns_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        is_uns = 1'b0;
        run_mult("sgn_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_mult_unit.md
BOOTH_MULT_UNIT -- requirements
Module: booth_mult_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: mc  input  WIDTH  multiplicand; sampled with accepted start.
REQ-006 SHALL have port: mp  input  WIDTH  multiplier; sampled with accepted start.
REQ-007 SHALL have port: is_unsigned  input  1  operand signedness; sampled with accepted start; present only when MULT_UNSIGNED_EN is defined.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port: done  output  1  single-cycle result-valid pulse.
REQ-010 SHALL have port: hi  output  WIDTH  upper half of product.
REQ-011 SHALL have port: lo  output  WIDTH  lower half of product.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 -> latch operands, clear accumulator, clear Q_1, load iteration count, go RUN; start=0 -> stay IDLE.
REQ-014 RUN: perform one radix-2 Booth step per cycle on {Q[0],Q_1}: 01 add M, 10 subtract M (two's complement), 00/11 none; then arithmetic right shift of {A,Q,Q_1}.
REQ-015 RUN SHALL last exactly L cycles, L = WIDTH (macro off) or WIDTH+1 (macro on), then go DONE.
REQ-016 DONE: assert done for exactly one cycle, update hi/lo with product, go IDLE unconditionally.
REQ-017 Latency: start accepted at edge k -> done high during cycle after edge k+L+1; hi/lo valid from that cycle.
REQ-018 hi/lo SHALL hold the last completed product until the next DONE; never show intermediate values.
REQ-019 start while busy SHALL be ignored with no effect on operands or progress.
REQ-020 Back-to-back: start high in the IDLE cycle following DONE SHALL be accepted.
REQ-021 Product SHALL be exact 2*WIDTH-bit result for all operands, including most-negative × most-negative.
REQ-022 Iteration counter SHALL be sized for L without wrap.

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, internal A/Q/M/Q_1/count=0.
REQ-024 reset SHALL override start and any in-progress operation; aborted operation SHALL never produce done.
REQ-025 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 Macro MULT_UNSIGNED_EN: defined -> is_unsigned port exists; datapath WIDTH+1 bits; operands sign-extended (is_unsigned=0) or zero-extended (is_unsigned=1); L=WIDTH+1 for both modes.
REQ-027 Macro undefined -> no is_unsigned port; signed-only WIDTH-bit datapath; L=WIDTH.

Structure
REQ-028 Shared package mult_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the Booth-op encoding constants.
REQ-029 One combinational sub-module booth_step SHALL compute add/subtract/none plus arithmetic shift for one iteration; booth_mult_unit instantiates it once.

Verification (WIDTH=32)
REQ-030 mc=7, mp=-3 (0xFFFFFFFD), start pulse -> done after L+1 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 mc=mp=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-032 Start accepted, reset pulsed at RUN cycle 10 -> no done; hi=lo=0; busy=0 the cycle after reset.
REQ-033 Product 5*6 running, start re-asserted with mc=mp=9 mid-RUN -> result hi=0, lo=30; done pulses once.
REQ-034 Macro defined, is_unsigned=1, mc=mp=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; same operands with is_unsigned=0 -> hi=0, lo=1.
REQ-035 Two starts back-to-back (second in IDLE cycle after DONE): 3*4 then -2*-2 -> lo=12 then lo=4, two done pulses L+2 cycles apart.
